wb_mast_seq: RTL and testbench
==============================

Name: wb_mast_seq

Overview:
Synthesizable, parametrised Wishbone classic master. It executes queued single read/write commands and returns one response per command. It is the next generation of the wb_mast bus master used in UART/SoC benches. Unlike that master, it buffers commands, handles err and rty with bounded retry, and enforces a bus timeout. It can act as a stimulus engine in benches or as an on-chip debug/bridge master ahead of the SoC interconnect.

Parameters:
AW, 32, address width
DW, 32, data width; must be a multiple of 8
SW, DW/8, byte-select width
DEPTH, 4, command FIFO depth; power of 2, minimum 2
TIMEOUT, 255, max cycles waiting for ack/err/rty per attempt; 8-bit counter
MAX_RETRY, 3, re-issues allowed after rty before giving up

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_we  in  1  1=write, 0=read
cmd_adr  in  AW  address
cmd_dat  in  DW  write data
cmd_sel  in  SW  byte selects
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_dat  out  DW  read data; 0 for writes and non-OK status
rsp_status  out  2  0=OK, 1=ERR, 2=RTY_EXHAUSTED, 3=TIMEOUT
busy  out  1  FIFO non-empty or FSM not IDLE
wb_adr_o  out  AW  bus address
wb_dat_o  out  DW  bus write data
wb_dat_i  in  DW  bus read data
wb_sel_o  out  SW  bus byte selects
wb_we_o  out  1  bus write enable
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  bus strobe
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  error
wb_rty_i  in  1  retry

Behaviour:
- Reset (async assert, sync release): FIFO empty, FSM=IDLE, all outputs 0, except cmd_ready=1.
- FIFO: push on cmd_valid&cmd_ready; cmd_ready=!full. Simultaneous push and pop when full is not allowed: cmd_ready is already low. Pointers wrap at DEPTH.
- FSM states: IDLE, BUS, RETRY, RESP.
- IDLE: if FIFO non-empty, pop and register adr/dat/sel/we, clear retry_cnt and tmo_cnt, go to BUS. wb_cyc_o and wb_stb_o rise on the following edge. A command accepted at edge k into an empty FIFO drives the bus after edge k+2.
- BUS: cyc=stb=1, bus outputs stable. On each edge, responses are sampled with priority err > rty > ack:
  - err: status=1, go to RESP.
  - rty with retry_cnt<MAX_RETRY: retry_cnt++, go to RETRY.
  - rty with retry_cnt==MAX_RETRY: status=2, go to RESP.
  - ack: status=0; capture wb_dat_i if read; go to RESP.
  - none: tmo_cnt++. When tmo_cnt reaches TIMEOUT: status=3, go to RESP. An ack in the same cycle as the timeout wins.
- Leaving BUS drops cyc/stb in the same registered update: a single-cycle bus release.
- RETRY: cyc=stb=0 for exactly one cycle, tmo_cnt cleared, return to BUS with the same command.
- RESP: rsp_valid=1, rsp_dat/rsp_status held stable. On rsp_ready, rsp_valid drops next edge and the FSM goes to IDLE. Back-to-back commands therefore have at least 2 idle bus cycles between them.
- Clean single-cycle ack with rsp_ready tied high: rsp_valid pulses 1 cycle after ack.
- Reset mid-transaction: bus signals drop immediately (async); queued commands are discarded; no response is issued.

Decomposition:
- Package wb_mast_seq_pkg: status encodings (ST_OK, ST_ERR, ST_RTY, ST_TMO), FSM state encodings.
- Sub-module wb_cmd_fifo: synchronous FIFO parametrised by width (1+AW+DW+SW) and DEPTH, with full/empty outputs and the same async reset.

Test Plan:
- Write 0xDEADBEEF to 0x10, sel=0xF, slave acks on the first stb cycle -> cyc high for exactly 1 cycle with adr=0x10, dat_o=0xDEADBEEF, we=1; then rsp_status=0, rsp_dat=0.
- Read 0x14, slave returns 0x12345678 with 3 wait states -> stb held 4 cycles; rsp_dat=0x12345678, status=0.
- Slave asserts rty twice, then ack -> three bus attempts, each separated by one cycle with cyc=0; status=0. With rty on every attempt -> 4 attempts (1+MAX_RETRY), then status=2.
- Slave never responds, TIMEOUT=255 -> cyc drops after 255 cycles; status=3. Ack and err together -> status=1.
- Push 5 commands with DEPTH=4 and rsp_ready=0 -> cmd_ready low once full. Responses return in push order; busy stays high until the last response is consumed.
- Assert rst during BUS wait -> cyc/stb/rsp_valid are 0 immediately; after release, FIFO is empty and cmd_ready=1.

Source files
------------

// File: rtl/wb_mast_seq_pkg.sv
// wb_mast_seq shared types
// Response status codes and master FSM states.
package wb_mast_seq_pkg;

  typedef enum logic [1:0] {
    ST_OK  = 2'd0,
    ST_ERR = 2'd1,
    ST_RTY = 2'd2,
    ST_TMO = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUS   = 2'd1,
    S_RETRY = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/wb_mast_seq_cmd_fifo.sv
// wb_cmd_fifo: synchronous command FIFO
// Extra pointer MSB separates full from empty.
module wb_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  r_wptr;
  logic [PW:0]  r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_wr;
  logic         w_rd;

  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PW] != r_rptr[PW]) &&
                   (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign o_dout  = r_mem[r_rptr[PW-1:0]];

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[PW-1:0]] <= i_din;
  end

endmodule

// File: rtl/wb_mast_seq.sv
// wb_mast_seq: queued Wishbone classic master
// Single read/write per command with retry and timeout.
module wb_mast_seq
  import wb_mast_seq_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int SW        = DW / 8,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [DW-1:0] cmd_dat,
  input  logic [SW-1:0] cmd_sel,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_dat,
  output logic [1:0]    rsp_status,
  output logic          busy,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  output logic [SW-1:0] wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  localparam int FW = 1 + AW + DW + SW;

  state_e        r_state, w_nxt_state;
  status_e       r_status, w_nxt_status;
  logic          r_we, w_nxt_we;
  logic [AW-1:0] r_adr, w_nxt_adr;
  logic [DW-1:0] r_dat, w_nxt_dat;
  logic [SW-1:0] r_sel, w_nxt_sel;
  logic          r_cyc, w_nxt_cyc;
  logic [7:0]    r_retry, w_nxt_retry;
  logic [7:0]    r_tmo, w_nxt_tmo;
  logic [DW-1:0] r_rdat, w_nxt_rdat;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [FW-1:0] w_fdout;
  logic          w_f_we;
  logic [AW-1:0] w_f_adr;
  logic [DW-1:0] w_f_dat;
  logic [SW-1:0] w_f_sel;

  assign cmd_ready = ~w_full;
  assign w_push    = cmd_valid & ~w_full;
  assign w_pop     = (r_state == S_IDLE) & ~w_empty;
  assign {w_f_we, w_f_adr, w_f_dat, w_f_sel} = w_fdout;

  wb_cmd_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   ({cmd_we, cmd_adr, cmd_dat, cmd_sel}),
    .i_pop   (w_pop),
    .o_dout  (w_fdout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_dat    = r_rdat;
  assign rsp_status = r_status;
  assign busy       = ~w_empty | (r_state != S_IDLE);
  assign wb_adr_o   = r_adr;
  assign wb_dat_o   = r_dat;
  assign wb_sel_o   = r_sel;
  assign wb_we_o    = r_we;
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_cyc;

  // State and command/response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_status <= ST_OK;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_sel    <= '0;
      r_cyc    <= 1'b0;
      r_retry  <= '0;
      r_tmo    <= '0;
      r_rdat   <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_status <= w_nxt_status;
      r_we     <= w_nxt_we;
      r_adr    <= w_nxt_adr;
      r_dat    <= w_nxt_dat;
      r_sel    <= w_nxt_sel;
      r_cyc    <= w_nxt_cyc;
      r_retry  <= w_nxt_retry;
      r_tmo    <= w_nxt_tmo;
      r_rdat   <= w_nxt_rdat;
    end
  end

  // Next state; bus responses only count once cyc is up.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_status = r_status;
    w_nxt_we     = r_we;
    w_nxt_adr    = r_adr;
    w_nxt_dat    = r_dat;
    w_nxt_sel    = r_sel;
    w_nxt_cyc    = r_cyc;
    w_nxt_retry  = r_retry;
    w_nxt_tmo    = r_tmo;
    w_nxt_rdat   = r_rdat;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_nxt_we     = w_f_we;
          w_nxt_adr    = w_f_adr;
          w_nxt_dat    = w_f_dat;
          w_nxt_sel    = w_f_sel;
          w_nxt_retry  = '0;
          w_nxt_tmo    = '0;
          w_nxt_status = ST_OK;
          w_nxt_rdat   = '0;
          w_nxt_state  = S_BUS;
        end
      end
      S_BUS: begin
        if (!r_cyc) begin
          w_nxt_cyc = 1'b1;
        end else if (wb_err_i) begin
          w_nxt_status = ST_ERR;
          w_nxt_rdat   = '0;
          w_nxt_cyc    = 1'b0;
          w_nxt_state  = S_RESP;
        end else if (wb_rty_i) begin
          w_nxt_cyc = 1'b0;
          if (r_retry == 8'(MAX_RETRY)) begin
            w_nxt_status = ST_RTY;
            w_nxt_rdat   = '0;
            w_nxt_state  = S_RESP;
          end else begin
            w_nxt_retry = r_retry + 8'd1;
            w_nxt_state = S_RETRY;
          end
        end else if (wb_ack_i) begin
          w_nxt_status = ST_OK;
          w_nxt_rdat   = r_we ? '0 : wb_dat_i;
          w_nxt_cyc    = 1'b0;
          w_nxt_state  = S_RESP;
        end else if (r_tmo == 8'(TIMEOUT - 1)) begin
          w_nxt_status = ST_TMO;
          w_nxt_rdat   = '0;
          w_nxt_cyc    = 1'b0;
          w_nxt_state  = S_RESP;
        end else begin
          w_nxt_tmo = r_tmo + 8'd1;
        end
      end
      S_RETRY: begin
        w_nxt_tmo   = '0;
        w_nxt_cyc   = 1'b1;
        w_nxt_state = S_BUS;
      end
      S_RESP: begin
        if (rsp_ready) w_nxt_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_mast_seq.sv
// tb_wb_mast_seq: directed bench for wb_mast_seq
// Scripted Wishbone slave driven from the stimulus process.
module tb_wb_mast_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;

  int n_chk  = 0;
  int n_fail = 0;

  // slave script: mode 0=ack 1=err 2=silent 3=ack+err
  int          sl_wait;
  int          sl_nrty;
  int          sl_mode;
  logic        sl_echo;
  logic [31:0] sl_rdata;

  // per-command bus observations
  int          tick;
  int          att;
  int          att_cyc;
  int          ncyc;
  int          first_tick;
  int          last_tick;
  logic        prev_cyc;
  logic [31:0] cap_adr;
  logic [31:0] cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we;

  always #5 clk = ~clk;

  assign wb_dat_i = sl_echo ? (wb_adr_o + 32'h1000) : sl_rdata;

  wb_mast_seq #(
    .AW        (32),
    .DW        (32),
    .SW        (4),
    .DEPTH     (4),
    .TIMEOUT   (255),
    .MAX_RETRY (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_dat    (cmd_dat),
    .cmd_sel    (cmd_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dat    (rsp_dat),
    .rsp_status (rsp_status),
    .busy       (busy),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .wb_rty_i   (wb_rty_i)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic begin_cmd();
    att        = 0;
    att_cyc    = 0;
    ncyc       = 0;
    first_tick = 0;
    last_tick  = 0;
  endtask

  // one clock: advance to negedge, then observe bus and drive slave
  task automatic step();
    logic hit;
    @(negedge clk);
    tick++;
    if (wb_cyc_o && wb_stb_o) begin
      if (!prev_cyc) begin
        att++;
        att_cyc = 0;
        if (att == 1) first_tick = tick;
      end
      last_tick = tick;
      ncyc++;
      cap_adr = wb_adr_o;
      cap_dat = wb_dat_o;
      cap_sel = wb_sel_o;
      cap_we  = wb_we_o;
      hit      = (att_cyc == sl_wait);
      wb_rty_i = hit && (att <= sl_nrty);
      wb_ack_i = hit && !wb_rty_i && (sl_mode == 0 || sl_mode == 3);
      wb_err_i = hit && !wb_rty_i && (sl_mode == 1 || sl_mode == 3);
      att_cyc++;
    end else begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_rty_i = 1'b0;
    end
    prev_cyc = wb_cyc_o;
  endtask

  task automatic push(input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel);
    int n;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    check("push_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 1000) begin
      step();
      lat++;
    end
    check("rsp_valid", rsp_valid, 1);
  endtask

  task automatic slave(input int w, input int nr, input int m,
                       input logic [31:0] rd);
    sl_wait  = w;
    sl_nrty  = nr;
    sl_mode  = m;
    sl_rdata = rd;
    begin_cmd();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic saw;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b1;
    wb_ack_i  = 1'b0;
    wb_err_i  = 1'b0;
    wb_rty_i  = 1'b0;
    sl_echo   = 1'b0;
    tick      = 0;
    prev_cyc  = 1'b0;
    cap_adr   = '0;
    cap_dat   = '0;
    cap_sel   = '0;
    cap_we    = 1'b0;
    slave(0, 0, 0, 32'h0);

    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    check("rst_adr", wb_adr_o, 0);
    rst = 1'b0;
    repeat (2) step();

    // write, ack on first strobe cycle
    slave(0, 0, 0, 32'hCAFE0000);
    push(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_rsp(lat);
    check("wr_latency", lat, 4);
    check("wr_ncyc", ncyc, 1);
    check("wr_adr", cap_adr, 32'h10);
    check("wr_dat", cap_dat, 32'hDEADBEEF);
    check("wr_we", cap_we, 1);
    check("wr_sel", cap_sel, 4'hF);
    check("wr_status", rsp_status, 0);
    check("wr_rdat", rsp_dat, 0);
    step();
    check("wr_busy_after", busy, 0);
    step();

    // read, three wait states
    slave(3, 0, 0, 32'h12345678);
    push(1'b0, 32'h14, 32'h0, 4'hF);
    wait_rsp(lat);
    check("rd_ncyc", ncyc, 4);
    check("rd_we", cap_we, 0);
    check("rd_adr", cap_adr, 32'h14);
    check("rd_status", rsp_status, 0);
    check("rd_rdat", rsp_dat, 32'h12345678);
    repeat (2) step();

    // two retries then ack
    slave(0, 2, 0, 32'hA1B2C3D4);
    push(1'b0, 32'h20, 32'h0, 4'h3);
    wait_rsp(lat);
    check("rty2_att", att, 3);
    check("rty2_ncyc", ncyc, 3);
    check("rty2_span", last_tick - first_tick + 1, 5);
    check("rty2_status", rsp_status, 0);
    check("rty2_rdat", rsp_dat, 32'hA1B2C3D4);
    repeat (2) step();

    // retry on every attempt
    slave(0, 99, 0, 32'h55AA55AA);
    push(1'b0, 32'h24, 32'h0, 4'hF);
    wait_rsp(lat);
    check("rtyx_att", att, 4);
    check("rtyx_ncyc", ncyc, 4);
    check("rtyx_status", rsp_status, 2);
    check("rtyx_rdat", rsp_dat, 0);
    repeat (2) step();

    // silent slave
    slave(0, 0, 2, 32'h77777777);
    push(1'b0, 32'h28, 32'h0, 4'hF);
    wait_rsp(lat);
    check("tmo_ncyc", ncyc, 255);
    check("tmo_att", att, 1);
    check("tmo_status", rsp_status, 3);
    check("tmo_rdat", rsp_dat, 0);
    repeat (2) step();

    // ack on the last cycle before timeout
    slave(254, 0, 0, 32'h0BADF00D);
    push(1'b0, 32'h2C, 32'h0, 4'hF);
    wait_rsp(lat);
    check("tmoack_ncyc", ncyc, 255);
    check("tmoack_status", rsp_status, 0);
    check("tmoack_rdat", rsp_dat, 32'h0BADF00D);
    repeat (2) step();

    // ack and err together
    slave(0, 0, 3, 32'h99999999);
    push(1'b0, 32'h30, 32'h0, 4'hF);
    wait_rsp(lat);
    check("ackerr_status", rsp_status, 1);
    check("ackerr_rdat", rsp_dat, 0);
    repeat (2) step();

    // fill FIFO while responses are held back
    slave(0, 0, 0, 32'h0);
    sl_echo   = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'hF);
    check("fifo_full_ready", cmd_ready, 0);
    check("fifo_full_busy", busy, 1);
    repeat (5) step();
    check("fifo_hold_ready", cmd_ready, 0);
    check("fifo_hold_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(lat);
      check("fifo_order", rsp_dat, 32'h1100 + 32'(4 * i));
      check("fifo_busy", busy, 1);
      step();
    end
    check("fifo_done_busy", busy, 0);
    check("fifo_done_ready", cmd_ready, 1);
    sl_echo = 1'b0;
    repeat (2) step();

    // reset during a bus wait with commands queued
    slave(0, 0, 2, 32'h0);
    push(1'b0, 32'h200, 32'h0, 4'hF);
    push(1'b1, 32'h204, 32'h1, 4'hF);
    push(1'b1, 32'h208, 32'h2, 4'hF);
    repeat (6) step();
    check("mid_cyc_before", wb_cyc_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_cyc", wb_cyc_o, 0);
    check("mid_rst_stb", wb_stb_o, 0);
    check("mid_rst_valid", rsp_valid, 0);
    repeat (2) step();
    rst = 1'b0;
    step();
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      saw = saw | wb_cyc_o | rsp_valid | busy;
    end
    check("post_rst_quiet", saw, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
